ticket_vend_ctrl: RTL and testbench
===================================

# ticket_vend_ctrl

Parametrised successor to the fixed four-ticket machine logic. It sits between the debounce/edge-detect stage and the display driver. It accumulates coin credit and validates a one-hot ticket selection against a parameter price table. On a valid sale it dispenses the ticket, then pays change as a stream of coin pulses gated by a hopper-ready handshake. It also supports cancel/refund, saturating total-sales accounting and a timed alarm.

## Interface

**Parameters**
- `N_TICKETS`, default 4: number of ticket types.
- `CREDIT_W`, default 8: width of credit and of each price.
- `SALES_W`, default 16: width of the total-sales accumulator.
- `PRICES`, default {8'd20, 8'd15, 8'd10, 8'd5}: packed price table; ticket i uses `[i*CREDIT_W +: CREDIT_W]`.
- `MAX_CREDIT`, default 99: credit ceiling.
- `VEND_CYCLES`, default 4: number of cycles `ticket_out` is held.
- `ALARM_CYCLES`, default 8: alarm duration in cycles.

**Ports**
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `coin_1`, `coin_5`, `coin_10` in 1 each: single-cycle coin pulses.
- `ticket_sel` in N_TICKETS: selection, sampled only on `confirm`.
- `confirm` in 1: single-cycle purchase request.
- `cancel` in 1: single-cycle refund request.
- `clear_sales` in 1: single-cycle clear of `total_sales`.
- `hopper_ready` in 1: change hopper can accept a coin this cycle.
- `credit` out CREDIT_W: current credit.
- `total_sales` out SALES_W: accumulated sales.
- `ticket_out` out N_TICKETS: one-hot dispensed ticket.
- `chg_1`, `chg_5`, `chg_10` out 1 each: change coin pulses.
- `coin_reject` out 1: one-cycle pulse when coin(s) are not accepted.
- `alarm` out 1: alarm active.
- `busy` out 1: high in VEND, CHANGE and ALARM.
- `state` out 3: IDLE=0, COLLECT=1, VEND=2, CHANGE=3, ALARM=4; used for display mode.

## Operation

**States**
- IDLE: credit is 0.
- COLLECT: credit > 0.
- VEND, CHANGE, ALARM as described below.

**Coins (IDLE/COLLECT)**
- `sum` = 1·coin_1 + 5·coin_5 + 10·coin_10, so simultaneous coins add together.
- If credit + sum ≤ MAX_CREDIT: add it; IDLE moves to COLLECT.
- Otherwise: credit is unchanged and `coin_reject` pulses.
- Coins arriving in any other state, or in the same cycle as `confirm`/`cancel`, are rejected.

**Cancel (IDLE/COLLECT)**
- Cancel has priority over confirm.
- With credit > 0: go to CHANGE, refunding all credit.
- With credit = 0: no effect.

**Confirm (IDLE/COLLECT)**
- If `ticket_sel` is not exactly one-hot, or credit < price[sel]: go to ALARM. Credit is kept.
- Otherwise:
  - credit −= price;
  - total_sales += price, saturating at 2^SALES_W−1;
  - latch `ticket_sel`;
  - go to VEND.

**VEND**
- `ticket_out` shows the latched selection for exactly VEND_CYCLES cycles.
- Then go to CHANGE if credit > 0, else IDLE.

**CHANGE**
- In each cycle with `hopper_ready` = 1, pulse the largest coin ≤ credit (10, then 5, then 1) and subtract its value.
- With `hopper_ready` = 0: no pulse and credit holds.
- When credit reaches 0, go to IDLE.

**ALARM**
- `alarm` = 1 for ALARM_CYCLES cycles.
- Then go to COLLECT if credit > 0, else IDLE.
- `confirm` and `cancel` are ignored during ALARM.

**Clear sales**
- `clear_sales` zeroes `total_sales` in any state.
- If it coincides with a sale, the result is `total_sales` = price (clear first, then add).

## Timing

- All outputs are registered.
- Effects of an input pulse on cycle N are visible on cycle N+1 (credit, state, `coin_reject`, `total_sales`, `alarm`).
- `ticket_out` asserts on N+1 after the accepted confirm and deasserts on N+1+VEND_CYCLES.
- Change pulses are one cycle wide, at most one per cycle.
  - A pulse on cycle M means `hopper_ready` was high on M−1.
  - The credit decrement is visible on the same cycle as the pulse.
- Reset values: all outputs 0, state IDLE, VEND/ALARM counters 0, latched selection 0.
- `rst` asserted mid-vend or mid-change aborts immediately. No further pulses are issued and credit is lost.
- Counters are wide enough for VEND_CYCLES/ALARM_CYCLES with no wrap.

## Test plan

- **Coin accumulation:** after reset, pulse coin_10, coin_5, coin_1 → credit 10, 15, 16; state 1.
- **Simultaneous coins and overflow:** at credit 95, pulse coin_5 and coin_1 together → credit 95 and `coin_reject` = 1. Then pulse coin_1 → credit 96.
- **Sale with change:** credit 27, `ticket_sel`=4'b0100 (price 15), confirm → `ticket_out`=0100 for 4 cycles, `total_sales`=15. Change output is chg_10 then chg_1 ×2, then state IDLE.
- **Hopper stall:** during change, hold `hopper_ready` low for 5 cycles → no pulses and credit constant. Release → pulses resume.
- **Alarm cases:** credit 8 with ticket 2 (price 15), or `ticket_sel`=0110, then confirm → `alarm` for 8 cycles, credit stays 8, return to COLLECT.
- **Cancel and clear:** cancel at credit 6 → chg_5, chg_1, IDLE. Then clear_sales in the same cycle as a price-10 sale → `total_sales`=10.

Source files
------------

// File: rtl/ticket_vend_ctrl.sv
// Ticket vending controller: accumulates coin credit, validates a one-hot
// ticket selection against a packed price table, dispenses for a fixed
// number of cycles, then pays change one hopper-gated coin per cycle.
// Also handles cancel/refund, a saturating sales total and a timed alarm.
module ticket_vend_ctrl #(
  parameter int unsigned                   N_TICKETS    = 4,
  parameter int unsigned                   CREDIT_W     = 8,
  parameter int unsigned                   SALES_W      = 16,
  parameter logic [N_TICKETS*CREDIT_W-1:0] PRICES       = {8'd20, 8'd15, 8'd10, 8'd5},
  parameter int unsigned                   MAX_CREDIT   = 99,
  parameter int unsigned                   VEND_CYCLES  = 4,
  parameter int unsigned                   ALARM_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 coin_1,
  input  logic                 coin_5,
  input  logic                 coin_10,
  input  logic [N_TICKETS-1:0] ticket_sel,
  input  logic                 confirm,
  input  logic                 cancel,
  input  logic                 clear_sales,
  input  logic                 hopper_ready,
  output logic [CREDIT_W-1:0]  credit,
  output logic [SALES_W-1:0]   total_sales,
  output logic [N_TICKETS-1:0] ticket_out,
  output logic                 chg_1,
  output logic                 chg_5,
  output logic                 chg_10,
  output logic                 coin_reject,
  output logic                 alarm,
  output logic                 busy,
  output logic [2:0]           state
);

  localparam int unsigned ADD_W     = CREDIT_W + 5;
  localparam int unsigned SUM_W     = ((SALES_W > CREDIT_W) ? SALES_W : CREDIT_W) + 1;
  localparam int unsigned MAX_CNT   = (VEND_CYCLES > ALARM_CYCLES) ? VEND_CYCLES : ALARM_CYCLES;
  localparam int unsigned CNT_W     = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int unsigned SEL_CNT_W = $clog2(N_TICKETS + 1);

  localparam logic [CNT_W-1:0] VEND_LAST  = CNT_W'(VEND_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALARM_LAST = CNT_W'(ALARM_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_VEND    = 3'd2,
    S_CHANGE  = 3'd3,
    S_ALARM   = 3'd4
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [4:0]           coin_sum;
  logic                 any_coin;
  logic [ADD_W-1:0]     credit_wide;
  logic [ADD_W-1:0]     credit_plus;
  logic                 coin_fits;

  logic [SEL_CNT_W-1:0] sel_count;
  logic [CREDIT_W-1:0]  sel_price;
  logic                 sale_ok;

  logic [SUM_W-1:0]     sales_base;
  logic [SUM_W-1:0]     sales_sum;
  logic [SALES_W-1:0]   sales_next;

  logic                 pick_10;
  logic                 pick_5;
  logic [CREDIT_W-1:0]  chg_val;

  assign state = state_q;

  // Coin value of this cycle and whether it fits under the credit ceiling
  assign coin_sum    = 5'(coin_1) + (coin_5 ? 5'd5 : 5'd0) + (coin_10 ? 5'd10 : 5'd0);
  assign any_coin    = coin_1 | coin_5 | coin_10;
  assign credit_wide = ADD_W'(credit);
  assign credit_plus = credit_wide + ADD_W'(coin_sum);
  assign coin_fits   = credit_plus <= ADD_W'(MAX_CREDIT);

  // Count selected bits and fetch the price of the (single) selected ticket
  always_comb begin
    sel_count = '0;
    sel_price = '0;
    for (int unsigned i = 0; i < N_TICKETS; i++) begin
      if (ticket_sel[i]) begin
        sel_count = sel_count + SEL_CNT_W'(1);
        sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
      end
    end
  end

  assign sale_ok = (sel_count == SEL_CNT_W'(1)) && (credit >= sel_price);

  // A clear coinciding with a sale leaves exactly the sale price
  assign sales_base = clear_sales ? '0 : SUM_W'(total_sales);
  assign sales_sum  = sales_base + SUM_W'(sel_price);
  assign sales_next = (sales_sum > SUM_W'({SALES_W{1'b1}})) ? '1 : sales_sum[SALES_W-1:0];

  // Largest coin not exceeding the remaining credit
  assign pick_10 = credit_wide >= ADD_W'(10);
  assign pick_5  = credit_wide >= ADD_W'(5);
  assign chg_val = pick_10 ? CREDIT_W'(10) : (pick_5 ? CREDIT_W'(5) : CREDIT_W'(1));

  // Control FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      credit      <= '0;
      total_sales <= '0;
      ticket_out  <= '0;
      chg_1       <= 1'b0;
      chg_5       <= 1'b0;
      chg_10      <= 1'b0;
      coin_reject <= 1'b0;
      alarm       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      coin_reject <= 1'b0;
      chg_1       <= 1'b0;
      chg_5       <= 1'b0;
      chg_10      <= 1'b0;

      if (clear_sales) begin
        total_sales <= '0;
      end

      case (state_q)
        S_IDLE, S_COLLECT: begin
          if (cancel) begin
            coin_reject <= any_coin;
            if (credit != '0) begin
              state_q <= S_CHANGE;
              busy    <= 1'b1;
            end
          end else if (confirm) begin
            coin_reject <= any_coin;
            cnt_q       <= '0;
            busy        <= 1'b1;
            if (sale_ok) begin
              credit      <= credit - sel_price;
              total_sales <= sales_next;
              ticket_out  <= ticket_sel;
              state_q     <= S_VEND;
            end else begin
              alarm   <= 1'b1;
              state_q <= S_ALARM;
            end
          end else if (any_coin) begin
            if (coin_fits) begin
              credit  <= credit_plus[CREDIT_W-1:0];
              state_q <= S_COLLECT;
            end else begin
              coin_reject <= 1'b1;
            end
          end
        end

        S_VEND: begin
          coin_reject <= any_coin;
          if (cnt_q == VEND_LAST) begin
            ticket_out <= '0;
            if (credit != '0) begin
              state_q <= S_CHANGE;
            end else begin
              state_q <= S_IDLE;
              busy    <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_CHANGE: begin
          coin_reject <= any_coin;
          if (credit == '0) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end else if (hopper_ready) begin
            chg_10 <= pick_10;
            chg_5  <= !pick_10 && pick_5;
            chg_1  <= !pick_10 && !pick_5;
            credit <= credit - chg_val;
            // Leave CHANGE on the same edge as the final coin
            if (credit == chg_val) begin
              state_q <= S_IDLE;
              busy    <= 1'b0;
            end
          end
        end

        S_ALARM: begin
          coin_reject <= any_coin;
          if (cnt_q == ALARM_LAST) begin
            alarm   <= 1'b0;
            busy    <= 1'b0;
            state_q <= (credit != '0) ? S_COLLECT : S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ticket_vend_ctrl.sv
// Scoreboard bench for ticket_vend_ctrl: stimulus pushes expected change
// coins, tickets, alarms and rejects into queues; a negedge monitor pops
// and compares whenever the DUT presents one of those outputs.
module tb_ticket_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_1, coin_5, coin_10;
  logic [3:0] ticket_sel;
  logic       confirm, cancel, clear_sales, hopper_ready;
  logic [7:0] credit;
  logic [7:0] total_sales;
  logic [3:0] ticket_out;
  logic       chg_1, chg_5, chg_10, coin_reject, alarm, busy;
  logic [2:0] state;

  ticket_vend_ctrl #(.SALES_W(8)) dut (
    .clk(clk), .rst(rst),
    .coin_1(coin_1), .coin_5(coin_5), .coin_10(coin_10),
    .ticket_sel(ticket_sel), .confirm(confirm), .cancel(cancel),
    .clear_sales(clear_sales), .hopper_ready(hopper_ready),
    .credit(credit), .total_sales(total_sales), .ticket_out(ticket_out),
    .chg_1(chg_1), .chg_5(chg_5), .chg_10(chg_10),
    .coin_reject(coin_reject), .alarm(alarm), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: credit, sales total, display state
  int m_credit = 0;
  int m_sales  = 0;
  int m_state  = 0;
  int price_tbl [4] = '{5, 10, 15, 20};

  int chg_q[$];
  int tkt_q[$];
  int alm_q[$];
  int rej_q[$];

  int         chg_count   = 0;
  logic       hop_prev    = 1'b0;
  logic [3:0] prev_tkt    = '0;
  int         tkt_len     = 0;
  logic       prev_alarm  = 1'b0;
  int         alm_len     = 0;
  int         prev_credit = 0;

  function automatic void check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic int price_of(logic [3:0] sel);
    int p = 0;
    for (int i = 0; i < 4; i++) if (sel[i]) p = price_tbl[i];
    return p;
  endfunction

  task automatic push_change(int amt);
    int a = amt;
    while (a >= 10) begin chg_q.push_back(10); a -= 10; end
    while (a >= 5)  begin chg_q.push_back(5);  a -= 5;  end
    while (a >= 1)  begin chg_q.push_back(1);  a -= 1;  end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    coin_1 = 0; coin_5 = 0; coin_10 = 0;
    confirm = 0; cancel = 0; clear_sales = 0; ticket_sel = '0;
  endtask

  always @(posedge clk) hop_prev <= hopper_ready;

  // Monitor: pop expectations when the DUT presents an output event
  always @(negedge clk) begin
    int nchg, val, e;
    if (rst) begin
      prev_tkt = '0; tkt_len = 0; prev_alarm = 1'b0; alm_len = 0; prev_credit = 0;
    end else begin
      nchg = int'(chg_1) + int'(chg_5) + int'(chg_10);
      if (nchg != 0) begin
        val = chg_10 ? 10 : (chg_5 ? 5 : 1);
        chg_count++;
        check("chg_onehot", nchg, 1);
        check("chg_hopper_prev", int'(hop_prev), 1);
        check("chg_decrement", int'(credit), prev_credit - val);
        if (chg_q.size() == 0) check("chg_unexpected", val, 0);
        else begin e = chg_q.pop_front(); check("chg_coin", val, e); end
      end
      if (coin_reject) begin
        if (rej_q.size() == 0) check("reject_unexpected", 1, 0);
        else begin e = rej_q.pop_front(); check("reject_credit", int'(credit), e); end
      end
      if (ticket_out != 4'd0) begin
        if (prev_tkt == 4'd0) begin
          tkt_len = 1;
          if (tkt_q.size() == 0) check("tkt_unexpected", int'(ticket_out), 0);
          else begin e = tkt_q.pop_front(); check("tkt_value", int'(ticket_out), e); end
        end else tkt_len++;
      end else if (prev_tkt != 4'd0) check("tkt_len", tkt_len, 4);
      if (alarm) begin
        if (!prev_alarm) begin
          alm_len = 1;
          if (alm_q.size() == 0) check("alarm_unexpected", 1, 0);
          else begin e = alm_q.pop_front(); check("alarm_credit", int'(credit), e); end
        end else alm_len++;
      end else if (prev_alarm) check("alarm_len", alm_len, 8);
      prev_tkt    = ticket_out;
      prev_alarm  = alarm;
      prev_credit = int'(credit);
    end
  end

  // Run until the DUT is back in IDLE/COLLECT, optionally stalling the hopper
  task automatic wait_done(bit stall);
    int n = 0;
    int k_hold;
    bit stalled = 0;
    while (!(busy == 1'b0 && (state == 3'd0 || state == 3'd1)) && n < 400) begin
      if (stall && !stalled && state == 3'd3) begin
        stalled = 1;
        hopper_ready = 1'b0;
        k_hold = chg_count;
        repeat (5) tick();
        check("stall_credit", int'(credit), m_credit);
        check("stall_pulses", chg_count - k_hold, 0);
      end
      hopper_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    check("done_in_budget", int'(n < 400), 1);
  endtask

  task automatic coins(bit c1, bit c5, bit c10);
    int s = int'(c1) + 5 * int'(c5) + 10 * int'(c10);
    if (s > 0) begin
      if (m_credit + s <= 99) begin m_credit += s; m_state = 1; end
      else rej_q.push_back(m_credit);
    end
    coin_1 = c1; coin_5 = c5; coin_10 = c10;
    tick();
    clear_inputs();
    check("coin_credit", int'(credit), m_credit);
    check("coin_state", int'(state), m_state);
  endtask

  task automatic do_confirm(logic [3:0] sel, bit with_clear, bit with_coin, bit stall);
    int  price = price_of(sel);
    bit  ok    = ($countones(sel) == 1) && (m_credit >= price);
    int  exp_state;
    if (ok) begin
      m_credit -= price;
      m_sales = (with_clear ? 0 : m_sales) + price;
      if (m_sales > 255) m_sales = 255;
      tkt_q.push_back(int'(sel));
      push_change(m_credit);
      exp_state = 2;
    end else begin
      if (with_clear) m_sales = 0;
      alm_q.push_back(m_credit);
      exp_state = 4;
    end
    if (with_coin) rej_q.push_back(m_credit);
    confirm = 1; ticket_sel = sel; clear_sales = with_clear; coin_10 = with_coin;
    tick();
    clear_inputs();
    check("confirm_state", int'(state), exp_state);
    check("confirm_busy", int'(busy), 1);
    check("confirm_credit", int'(credit), m_credit);
    check("confirm_sales", int'(total_sales), m_sales);
    if (!ok) begin
      // confirm is ignored and coins rejected while the alarm runs
      rej_q.push_back(m_credit);
      confirm = 1; ticket_sel = 4'b0001; coin_10 = 1;
      tick();
      clear_inputs();
    end
    wait_done(stall);
    if (ok) m_credit = 0;
    m_state = (m_credit > 0) ? 1 : 0;
    check("done_state", int'(state), m_state);
    check("done_credit", int'(credit), m_credit);
    check("done_sales", int'(total_sales), m_sales);
  endtask

  task automatic do_cancel(bit with_coin);
    int exp_state = m_state;
    if (with_coin) rej_q.push_back(m_credit);
    if (m_credit > 0) begin push_change(m_credit); exp_state = 3; end
    cancel = 1; coin_5 = with_coin;
    tick();
    clear_inputs();
    check("cancel_state", int'(state), exp_state);
    if (m_credit > 0) begin
      wait_done(0);
      m_credit = 0;
      m_state  = 0;
    end
    check("cancel_credit", int'(credit), m_credit);
    check("cancel_done_state", int'(state), m_state);
  endtask

  task automatic do_clear();
    clear_sales = 1;
    m_sales = 0;
    tick();
    clear_inputs();
    check("clear_sales", int'(total_sales), m_sales);
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k0, n, r;
    logic [3:0] s;
    rst = 1; hopper_ready = 0;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_credit", int'(credit), 0);
    check("rst_state", int'(state), 0);
    check("rst_sales", int'(total_sales), 0);
    check("rst_ticket", int'(ticket_out), 0);
    check("rst_alarm", int'(alarm), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_chg", int'({chg_1, chg_5, chg_10}), 0);
    check("rst_reject", int'(coin_reject), 0);
    rst = 0;
    tick();

    // accumulation 10, 15, 16
    coins(0, 0, 1); coins(0, 1, 0); coins(1, 0, 0);
    // up to 95, then simultaneous 5+1 overflows, then 1 fits
    repeat (7) coins(0, 0, 1);
    coins(0, 1, 0);
    repeat (4) coins(1, 0, 0);
    coins(1, 1, 0);
    coins(1, 0, 0);
    do_cancel(0);

    // sale at 27 for ticket 2 (price 15) with hopper stall during change
    coins(0, 0, 1); coins(0, 0, 1); coins(0, 1, 0); coins(1, 0, 0); coins(1, 0, 0);
    do_confirm(4'b0100, 0, 0, 1);

    // alarms at credit 8: insufficient credit, then non-one-hot selection
    coins(0, 1, 0); repeat (3) coins(1, 0, 0);
    do_confirm(4'b0100, 0, 0, 0);
    do_confirm(4'b0110, 0, 0, 0);
    do_cancel(0);

    // cancel at 6, then clear coinciding with a price-10 sale
    coins(0, 1, 0); coins(1, 0, 0);
    do_cancel(0);
    coins(0, 0, 1);
    do_confirm(4'b0010, 1, 0, 0);
    check("clear_with_sale", int'(total_sales), 10);

    // drive the 8-bit sales total into saturation
    repeat (13) begin
      coins(0, 0, 1); coins(0, 0, 1);
      do_confirm(4'b1000, 0, 0, 0);
    end
    check("sales_saturated", int'(total_sales), 255);
    do_clear();

    // randomized mix
    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        coins(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (r <= 6) begin
        if ($urandom_range(0, 3) == 0) s = 4'($urandom_range(0, 15));
        else s = 4'(1 << $urandom_range(0, 3));
        do_confirm(s, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0));
      end else if (r == 7) begin
        do_cancel(($urandom_range(0, 3) == 0));
      end else if (r == 8) begin
        do_clear();
      end else begin
        coins(0, 0, 1);
      end
    end

    // reset in the middle of change payout
    while (m_credit + 10 <= 99 && m_credit < 30) coins(0, 0, 1);
    hopper_ready = 1;
    tkt_q.push_back(1);
    push_change(m_credit - 5);
    confirm = 1; ticket_sel = 4'b0001;
    tick();
    clear_inputs();
    k0 = chg_count;
    n = 0;
    while (chg_count == k0 && n < 100) begin tick(); n++; end
    check("rst_reach_change", int'(n < 100), 1);
    rst = 1;
    chg_q.delete();
    m_credit = 0; m_sales = 0; m_state = 0;
    tick(); tick();
    rst = 0;
    k0 = chg_count;
    repeat (5) tick();
    check("abort_pulses", chg_count - k0, 0);
    check("abort_credit", int'(credit), m_credit);
    check("abort_state", int'(state), m_state);
    check("abort_busy", int'(busy), 0);
    check("abort_sales", int'(total_sales), m_sales);
    check("abort_ticket", int'(ticket_out), 0);

    repeat (3) tick();
    check("chg_q_empty", chg_q.size(), 0);
    check("tkt_q_empty", tkt_q.size(), 0);
    check("alm_q_empty", alm_q.size(), 0);
    check("rej_q_empty", rej_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
